// File: rtl/complex_mult_pkg.sv
// Shared types and default widths for the complex multiplier arbiter slice.
package complex_mult_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH     = 8;
  localparam int unsigned DEFAULT_RES_WIDTH      = 2 * DEFAULT_DATA_WIDTH + 1;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 64;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_RES = 2'd2,
    ST_RETURN   = 2'd3
  } arb_state_t;

  typedef logic grant_id_t;

endpackage

// File: rtl/complex_mult_arbiter_if.sv
// Requester and multiplier handshake bundle; master is the arbiter's view, slave the environment's.
interface complex_mult_arbiter_if
  import complex_mult_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned RES_WIDTH  = DEFAULT_RES_WIDTH
);
  logic                  req0_op_val, req0_op_ready;
  logic [DATA_WIDTH-1:0] req0_op_1_re, req0_op_1_im, req0_op_2_re, req0_op_2_im;
  logic                  req0_res_val, req0_res_ready, req0_res_err;
  logic [RES_WIDTH-1:0]  req0_res_re, req0_res_im;

  logic                  req1_op_val, req1_op_ready;
  logic [DATA_WIDTH-1:0] req1_op_1_re, req1_op_1_im, req1_op_2_re, req1_op_2_im;
  logic                  req1_res_val, req1_res_ready, req1_res_err;
  logic [RES_WIDTH-1:0]  req1_res_re, req1_res_im;

  logic                  mult_sw_rst;
  logic                  mult_op_val, mult_op_ready;
  logic [DATA_WIDTH-1:0] mult_op_1_re, mult_op_1_im, mult_op_2_re, mult_op_2_im;
  logic                  mult_res_val, mult_res_ready;
  logic [RES_WIDTH-1:0]  mult_res_re, mult_res_im;
  logic                  timeout_err;

  modport master (
    input  req0_op_val, req0_op_1_re, req0_op_1_im, req0_op_2_re, req0_op_2_im, req0_res_ready,
    output req0_op_ready, req0_res_val, req0_res_re, req0_res_im, req0_res_err,
    input  req1_op_val, req1_op_1_re, req1_op_1_im, req1_op_2_re, req1_op_2_im, req1_res_ready,
    output req1_op_ready, req1_res_val, req1_res_re, req1_res_im, req1_res_err,
    output mult_sw_rst, mult_op_val, mult_op_1_re, mult_op_1_im, mult_op_2_re, mult_op_2_im,
    input  mult_op_ready,
    input  mult_res_val, mult_res_re, mult_res_im,
    output mult_res_ready, timeout_err
  );

  modport slave (
    output req0_op_val, req0_op_1_re, req0_op_1_im, req0_op_2_re, req0_op_2_im, req0_res_ready,
    input  req0_op_ready, req0_res_val, req0_res_re, req0_res_im, req0_res_err,
    output req1_op_val, req1_op_1_re, req1_op_1_im, req1_op_2_re, req1_op_2_im, req1_res_ready,
    input  req1_op_ready, req1_res_val, req1_res_re, req1_res_im, req1_res_err,
    input  mult_sw_rst, mult_op_val, mult_op_1_re, mult_op_1_im, mult_op_2_re, mult_op_2_im,
    output mult_op_ready,
    output mult_res_val, mult_res_re, mult_res_im,
    input  mult_res_ready, timeout_err
  );
endinterface

// File: rtl/complex_mult_arbiter_rr_arb2.sv
// Two-way round-robin grant: on a tie the requester not served last wins.
module rr_arb2
  import complex_mult_pkg::*;
(
  input  logic      valid0,
  input  logic      valid1,
  input  grant_id_t last_grant,
  output logic      gnt_valid,
  output grant_id_t gnt_id
);
  always_comb begin
    gnt_valid = valid0 | valid1;
    if (valid0 && valid1) gnt_id = ~last_grant;
    else                  gnt_id = valid1;
  end
endmodule

// File: rtl/complex_mult_arbiter.sv
// Shares one complex multiplier between two requesters, one operation in flight,
// with a result watchdog that returns a zeroed error result on timeout.
module complex_mult_arbiter
  import complex_mult_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int unsigned RES_WIDTH      = DEFAULT_RES_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input logic                    clk,
  input logic                    rstn,
  input logic                    sw_rst,
  complex_mult_arbiter_if.master bus
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_t            state, state_nxt;
  grant_id_t             grant, last_grant, gnt_id;
  logic                  gnt_valid, res_ready_g;
  logic                  accept, take_res, timeout_hit, deliver;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] op_1_re, op_1_im, op_2_re, op_2_im;
  logic [RES_WIDTH-1:0]  res_re, res_im;
  logic                  res_err, timeout_err;
  logic                  ret0, ret1;

  rr_arb2 u_rr (
    .valid0    (bus.req0_op_val),
    .valid1    (bus.req1_op_val),
    .last_grant(last_grant),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  assign res_ready_g = grant ? bus.req1_res_ready : bus.req0_res_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    take_res    = 1'b0;
    timeout_hit = 1'b0;
    deliver     = 1'b0;
    unique case (state)
      ST_IDLE:     if (gnt_valid) begin accept = 1'b1; state_nxt = ST_ISSUE; end
      ST_ISSUE:    if (bus.mult_op_ready) state_nxt = ST_WAIT_RES;
      ST_WAIT_RES: begin
        // A real result on the terminal-count edge takes priority over the timeout.
        if (bus.mult_res_val) begin
          take_res  = 1'b1;
          state_nxt = ST_RETURN;
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES)) begin
          timeout_hit = 1'b1;
          state_nxt   = ST_RETURN;
        end
      end
      ST_RETURN:   if (res_ready_g) begin deliver = 1'b1; state_nxt = ST_IDLE; end
      default:     state_nxt = ST_IDLE;
    endcase
    if (sw_rst) begin
      state_nxt   = ST_IDLE;
      accept      = 1'b0;
      take_res    = 1'b0;
      timeout_hit = 1'b0;
      deliver     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      grant <= 1'b0; last_grant <= 1'b1; cnt <= '0;
      op_1_re <= '0; op_1_im <= '0; op_2_re <= '0; op_2_im <= '0;
      res_re <= '0; res_im <= '0; res_err <= 1'b0; timeout_err <= 1'b0;
    end else if (sw_rst) begin
      grant <= 1'b0; last_grant <= 1'b1; cnt <= '0;
      op_1_re <= '0; op_1_im <= '0; op_2_re <= '0; op_2_im <= '0;
      res_re <= '0; res_im <= '0; res_err <= 1'b0; timeout_err <= 1'b0;
    end else begin
      if (accept) begin
        grant   <= gnt_id;
        op_1_re <= gnt_id ? bus.req1_op_1_re : bus.req0_op_1_re;
        op_1_im <= gnt_id ? bus.req1_op_1_im : bus.req0_op_1_im;
        op_2_re <= gnt_id ? bus.req1_op_2_re : bus.req0_op_2_re;
        op_2_im <= gnt_id ? bus.req1_op_2_im : bus.req0_op_2_im;
      end
      if (state == ST_ISSUE)         cnt <= '0;
      else if (state == ST_WAIT_RES) cnt <= cnt + CNT_W'(1);
      if (take_res) begin
        res_re  <= bus.mult_res_re;
        res_im  <= bus.mult_res_im;
        res_err <= 1'b0;
      end else if (timeout_hit) begin
        res_re      <= '0;
        res_im      <= '0;
        res_err     <= 1'b1;
        timeout_err <= 1'b1;
      end
      if (deliver) last_grant <= grant;
    end
  end

  assign ret0 = (state == ST_RETURN) && (grant == 1'b0);
  assign ret1 = (state == ST_RETURN) && (grant == 1'b1);

  assign bus.req0_op_ready  = accept && (gnt_id == 1'b0);
  assign bus.req1_op_ready  = accept && (gnt_id == 1'b1);
  assign bus.req0_res_val   = ret0 && !sw_rst;
  assign bus.req1_res_val   = ret1 && !sw_rst;
  assign bus.req0_res_re    = ret0 ? res_re : '0;
  assign bus.req0_res_im    = ret0 ? res_im : '0;
  assign bus.req0_res_err   = ret0 ? res_err : 1'b0;
  assign bus.req1_res_re    = ret1 ? res_re : '0;
  assign bus.req1_res_im    = ret1 ? res_im : '0;
  assign bus.req1_res_err   = ret1 ? res_err : 1'b0;
  assign bus.mult_sw_rst    = sw_rst;
  assign bus.mult_op_val    = (state == ST_ISSUE) && !sw_rst;
  assign bus.mult_op_1_re   = op_1_re;
  assign bus.mult_op_1_im   = op_1_im;
  assign bus.mult_op_2_re   = op_2_re;
  assign bus.mult_op_2_im   = op_2_im;
  assign bus.mult_res_ready = (state == ST_WAIT_RES) && !sw_rst;
  assign bus.timeout_err    = timeout_err;
endmodule

// File: tb/tb_complex_mult_arbiter.sv
// Directed bench: vector table on a default-timeout instance, hand sequences on a short-timeout instance.
module tb_complex_mult_arbiter;
  localparam int unsigned DW = 8;
  localparam int unsigned RW = 17;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic sw_rst_m = 1'b0;
  logic sw_rst_t = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  complex_mult_arbiter_if #(.DATA_WIDTH(DW), .RES_WIDTH(RW)) bus_m ();
  complex_mult_arbiter_if #(.DATA_WIDTH(DW), .RES_WIDTH(RW)) bus_t ();

  complex_mult_arbiter #(.DATA_WIDTH(DW), .RES_WIDTH(RW), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rstn(rstn), .sw_rst(sw_rst_m), .bus(bus_m)
  );
  complex_mult_arbiter #(.DATA_WIDTH(DW), .RES_WIDTH(RW), .TIMEOUT_CYCLES(8)) dut_to (
    .clk(clk), .rstn(rstn), .sw_rst(sw_rst_t), .bus(bus_t)
  );

  typedef struct {
    logic [1:0] req_val;
    int exp_g;
    int a_re, a_im, b_re, b_im;
    int exp_re, exp_im;
    int opr_delay, res_delay, rdy_delay;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_ops_m(input logic w, input int ar, input int ai, input int br, input int bi);
    if (!w) begin
      bus_m.req0_op_1_re = DW'(ar); bus_m.req0_op_1_im = DW'(ai);
      bus_m.req0_op_2_re = DW'(br); bus_m.req0_op_2_im = DW'(bi);
    end else begin
      bus_m.req1_op_1_re = DW'(ar); bus_m.req1_op_1_im = DW'(ai);
      bus_m.req1_op_2_re = DW'(br); bus_m.req1_op_2_im = DW'(bi);
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic g;
    int x1r, x1i, x2r, x2i, pr, pi;
    g = (v.exp_g != 0);
    pr = 0; pi = 0;
    @(negedge clk);
    set_ops_m(g, v.a_re, v.a_im, v.b_re, v.b_im);
    set_ops_m(!g, 85, 85, 85, 85);
    bus_m.req0_op_val = v.req_val[0];
    bus_m.req1_op_val = v.req_val[1];
    #1;
    check("op_ready0", {31'd0, bus_m.req0_op_ready}, {31'd0, !g});
    check("op_ready1", {31'd0, bus_m.req1_op_ready}, {31'd0, g});
    @(posedge clk);
    for (int i = 0; i <= v.opr_delay; i++) begin
      @(negedge clk);
      if (i == 0) begin bus_m.req0_op_val = 1'b0; bus_m.req1_op_val = 1'b0; end
      check("mult_op_val", {31'd0, bus_m.mult_op_val}, 32'd1);
      check("mult_op_1_re", {24'd0, bus_m.mult_op_1_re}, {24'd0, DW'(v.a_re)});
      check("mult_op_1_im", {24'd0, bus_m.mult_op_1_im}, {24'd0, DW'(v.a_im)});
      check("mult_op_2_re", {24'd0, bus_m.mult_op_2_re}, {24'd0, DW'(v.b_re)});
      check("mult_op_2_im", {24'd0, bus_m.mult_op_2_im}, {24'd0, DW'(v.b_im)});
      if (i == v.opr_delay) begin
        bus_m.mult_op_ready = 1'b1;
        x1r = $signed(bus_m.mult_op_1_re); x1i = $signed(bus_m.mult_op_1_im);
        x2r = $signed(bus_m.mult_op_2_re); x2i = $signed(bus_m.mult_op_2_im);
        pr = x1r * x2r - x1i * x2i;
        pi = x1r * x2i + x1i * x2r;
      end
    end
    @(negedge clk);
    bus_m.mult_op_ready = 1'b0;
    check("mult_op_val_drop", {31'd0, bus_m.mult_op_val}, 32'd0);
    check("mult_res_ready", {31'd0, bus_m.mult_res_ready}, 32'd1);
    repeat (v.res_delay) @(negedge clk);
    bus_m.mult_res_val = 1'b1;
    bus_m.mult_res_re = RW'(pr);
    bus_m.mult_res_im = RW'(pi);
    @(negedge clk);
    bus_m.mult_res_val = 1'b0;
    bus_m.mult_res_re = '0;
    bus_m.mult_res_im = '0;
    check("mult_res_ready_drop", {31'd0, bus_m.mult_res_ready}, 32'd0);
    for (int i = 0; i <= v.rdy_delay; i++) begin
      if (i > 0) @(negedge clk);
      check("res_val", {31'd0, g ? bus_m.req1_res_val : bus_m.req0_res_val}, 32'd1);
      check("res_val_other", {31'd0, g ? bus_m.req0_res_val : bus_m.req1_res_val}, 32'd0);
      check("res_re", {15'd0, g ? bus_m.req1_res_re : bus_m.req0_res_re}, {15'd0, RW'(v.exp_re)});
      check("res_im", {15'd0, g ? bus_m.req1_res_im : bus_m.req0_res_im}, {15'd0, RW'(v.exp_im)});
      check("res_err", {31'd0, g ? bus_m.req1_res_err : bus_m.req0_res_err}, 32'd0);
      check("res_re_other", {15'd0, g ? bus_m.req0_res_re : bus_m.req1_res_re}, 32'd0);
      if (i > 0)
        check("op_ready_other_hold", {31'd0, g ? bus_m.req0_op_ready : bus_m.req1_op_ready}, 32'd0);
      if (i == 0 && v.rdy_delay > 0) begin
        if (g) bus_m.req0_op_val = 1'b1; else bus_m.req1_op_val = 1'b1;
      end
      if (i == v.rdy_delay) begin
        if (g) bus_m.req1_res_ready = 1'b1; else bus_m.req0_res_ready = 1'b1;
        bus_m.req0_op_val = 1'b0;
        bus_m.req1_op_val = 1'b0;
      end
    end
    @(negedge clk);
    bus_m.req0_res_ready = 1'b0;
    bus_m.req1_res_ready = 1'b0;
    check("res_val0_done", {31'd0, bus_m.req0_res_val}, 32'd0);
    check("res_val1_done", {31'd0, bus_m.req1_res_val}, 32'd0);
    check("mult_op_val_idle", {31'd0, bus_m.mult_op_val}, 32'd0);
  endtask

  task automatic to_start(input logic w, input int ar, input int ai, input int br, input int bi);
    @(negedge clk);
    if (!w) begin
      bus_t.req0_op_1_re = DW'(ar); bus_t.req0_op_1_im = DW'(ai);
      bus_t.req0_op_2_re = DW'(br); bus_t.req0_op_2_im = DW'(bi);
      bus_t.req0_op_val = 1'b1;
    end else begin
      bus_t.req1_op_1_re = DW'(ar); bus_t.req1_op_1_im = DW'(ai);
      bus_t.req1_op_2_re = DW'(br); bus_t.req1_op_2_im = DW'(bi);
      bus_t.req1_op_val = 1'b1;
    end
    #1;
    check("to_op_ready", {31'd0, w ? bus_t.req1_op_ready : bus_t.req0_op_ready}, 32'd1);
    @(negedge clk);
    bus_t.req0_op_val = 1'b0;
    bus_t.req1_op_val = 1'b0;
    check("to_mult_op_val", {31'd0, bus_t.mult_op_val}, 32'd1);
    bus_t.mult_op_ready = 1'b1;
    @(negedge clk);
    bus_t.mult_op_ready = 1'b0;
    check("to_mult_res_ready", {31'd0, bus_t.mult_res_ready}, 32'd1);
  endtask

  task automatic to_finish(input logic w, input int er, input int ei, input logic eerr);
    check("to_res_val", {31'd0, w ? bus_t.req1_res_val : bus_t.req0_res_val}, 32'd1);
    check("to_res_val_other", {31'd0, w ? bus_t.req0_res_val : bus_t.req1_res_val}, 32'd0);
    check("to_res_re", {15'd0, w ? bus_t.req1_res_re : bus_t.req0_res_re}, {15'd0, RW'(er)});
    check("to_res_im", {15'd0, w ? bus_t.req1_res_im : bus_t.req0_res_im}, {15'd0, RW'(ei)});
    check("to_res_err", {31'd0, w ? bus_t.req1_res_err : bus_t.req0_res_err}, {31'd0, eerr});
    if (w) bus_t.req1_res_ready = 1'b1; else bus_t.req0_res_ready = 1'b1;
    @(negedge clk);
    bus_t.req0_res_ready = 1'b0;
    bus_t.req1_res_ready = 1'b0;
    check("to_res_val_done", {31'd0, w ? bus_t.req1_res_val : bus_t.req0_res_val}, 32'd0);
  endtask

  task automatic clear_bus_inputs();
    bus_m.req0_op_val = 1'b0; bus_m.req1_op_val = 1'b0;
    bus_m.req0_res_ready = 1'b0; bus_m.req1_res_ready = 1'b0;
    bus_m.mult_op_ready = 1'b0; bus_m.mult_res_val = 1'b0;
    bus_m.mult_res_re = '0; bus_m.mult_res_im = '0;
    set_ops_m(1'b0, 0, 0, 0, 0);
    set_ops_m(1'b1, 0, 0, 0, 0);
    bus_t.req0_op_val = 1'b0; bus_t.req1_op_val = 1'b0;
    bus_t.req0_res_ready = 1'b0; bus_t.req1_res_ready = 1'b0;
    bus_t.mult_op_ready = 1'b0; bus_t.mult_res_val = 1'b0;
    bus_t.mult_res_re = '0; bus_t.mult_res_im = '0;
    bus_t.req0_op_1_re = '0; bus_t.req0_op_1_im = '0; bus_t.req0_op_2_re = '0; bus_t.req0_op_2_im = '0;
    bus_t.req1_op_1_re = '0; bus_t.req1_op_1_im = '0; bus_t.req1_op_2_re = '0; bus_t.req1_op_2_im = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          req_val g  a_re a_im b_re b_im  exp_re exp_im  opr res rdy
    vecs[0] = '{2'b11, 0,    1,   1,   1,  -1,      2,     0,  0,  0,  0};
    vecs[1] = '{2'b11, 1,   -3,   2,   5,   4,    -23,    -2,  0,  0,  0};
    vecs[2] = '{2'b11, 0,    2,   3,   4,   2,      2,    16,  5,  0,  0};
    vecs[3] = '{2'b01, 0,    2,   3,   4,   2,      2,    16,  0, 20,  0};
    vecs[4] = '{2'b10, 1,  127,-128,-128, 127,      0, 32513,  0,  1, 10};
    vecs[5] = '{2'b11, 0, -128,-128,-128,-128,      0, 32768,  2,  3,  3};

    clear_bus_inputs();
    repeat (3) @(negedge clk);
    check("rst_op_ready0", {31'd0, bus_m.req0_op_ready}, 32'd0);
    check("rst_mult_op_val", {31'd0, bus_m.mult_op_val}, 32'd0);
    check("rst_mult_res_ready", {31'd0, bus_m.mult_res_ready}, 32'd0);
    check("rst_res_val0", {31'd0, bus_m.req0_res_val}, 32'd0);
    check("rst_res_val1", {31'd0, bus_m.req1_res_val}, 32'd0);
    check("rst_mult_op_1_re", {24'd0, bus_m.mult_op_1_re}, 32'd0);
    check("rst_timeout_err", {31'd0, bus_m.timeout_err}, 32'd0);
    check("rst_mult_sw_rst", {31'd0, bus_m.mult_sw_rst}, 32'd0);
    rstn = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Short-timeout instance: normal, timeout, result on terminal count, sw_rst abort.
    to_start(1'b1, 2, 1, 3, 2);
    bus_t.mult_res_val = 1'b1; bus_t.mult_res_re = RW'(4); bus_t.mult_res_im = RW'(7);
    @(negedge clk);
    bus_t.mult_res_val = 1'b0;
    to_finish(1'b1, 4, 7, 1'b0);
    check("to_timeout_err_clear", {31'd0, bus_t.timeout_err}, 32'd0);

    to_start(1'b0, 1, 1, 1, 1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("to_wait_res_val", {31'd0, bus_t.req0_res_val}, 32'd0);
      check("to_wait_res_ready", {31'd0, bus_t.mult_res_ready}, 32'd1);
    end
    @(negedge clk);
    check("to_timeout_err_set", {31'd0, bus_t.timeout_err}, 32'd1);
    to_finish(1'b0, 0, 0, 1'b1);

    to_start(1'b1, -1, 2, 3, -1);
    repeat (8) @(negedge clk);
    bus_t.mult_res_val = 1'b1; bus_t.mult_res_re = RW'(-1); bus_t.mult_res_im = RW'(7);
    @(negedge clk);
    bus_t.mult_res_val = 1'b0;
    to_finish(1'b1, -1, 7, 1'b0);
    check("to_timeout_err_sticky", {31'd0, bus_t.timeout_err}, 32'd1);

    to_start(1'b0, 3, 3, 3, 3);
    @(negedge clk);
    sw_rst_t = 1'b1;
    #1;
    check("sw_mult_sw_rst_hi", {31'd0, bus_t.mult_sw_rst}, 32'd1);
    check("sw_mult_res_ready_gated", {31'd0, bus_t.mult_res_ready}, 32'd0);
    @(negedge clk);
    sw_rst_t = 1'b0;
    check("sw_mult_sw_rst_lo", {31'd0, bus_t.mult_sw_rst}, 32'd0);
    check("sw_timeout_err", {31'd0, bus_t.timeout_err}, 32'd0);
    check("sw_mult_res_ready", {31'd0, bus_t.mult_res_ready}, 32'd0);
    check("sw_mult_op_val", {31'd0, bus_t.mult_op_val}, 32'd0);
    check("sw_mult_op_1_re", {24'd0, bus_t.mult_op_1_re}, 32'd0);
    check("sw_res_val0", {31'd0, bus_t.req0_res_val}, 32'd0);
    bus_t.mult_res_val = 1'b1; bus_t.mult_res_re = RW'(5); bus_t.mult_res_im = RW'(5);
    @(negedge clk);
    bus_t.mult_res_val = 1'b0;
    check("late_res_val0", {31'd0, bus_t.req0_res_val}, 32'd0);
    check("late_res_val1", {31'd0, bus_t.req1_res_val}, 32'd0);
    bus_t.req0_op_val = 1'b1;
    bus_t.req1_op_val = 1'b1;
    #1;
    check("post_sw_tie_ready0", {31'd0, bus_t.req0_op_ready}, 32'd1);
    check("post_sw_tie_ready1", {31'd0, bus_t.req1_op_ready}, 32'd0);
    bus_t.req0_op_val = 1'b0;
    bus_t.req1_op_val = 1'b0;
    @(negedge clk);
    check("drop_before_accept", {31'd0, bus_t.mult_op_val}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/complex_mult_arbiter.md
# complex_mult_arbiter

Round-robin arbiter sharing one complex number multiplier instance between two requesters. Accepts operands over a valid/ready handshake, registers them, issues them to the multiplier, then routes the returned product to the originating requester. Sits between the two operand producers and the multiplier's op/res handshake ports. It also supervises the multiplier with a result-timeout watchdog.

## Interface
- DATA_WIDTH, 8, operand component width (two's complement)
- RES_WIDTH, 17, result component width (2*DATA_WIDTH+1), passed through unchanged
- TIMEOUT_CYCLES, 64, max cycles in WAIT_RES before timeout (1..1023)

Ports:
- clk  in  1  clock, all logic on rising edge
- rstn  in  1  asynchronous reset, active low
- sw_rst  in  1  synchronous software reset, active high
- reqN_op_val  in  1  (N=0,1) requester N operands valid
- reqN_op_ready  out  1  requester N operands accepted this cycle
- reqN_op_1_re/_1_im/_2_re/_2_im  in  DATA_WIDTH each  requester N operands
- reqN_res_val  out  1  result for requester N valid
- reqN_res_ready  in  1  requester N takes result
- reqN_res_re/_res_im  out  RES_WIDTH  result data
- reqN_res_err  out  1  result is a timeout marker (data forced 0)
- mult_sw_rst  out  1  = sw_rst, combinational
- mult_op_val  out  1  operands valid to multiplier
- mult_op_ready  in  1  multiplier accepts operands
- mult_op_1_re/_1_im/_2_re/_2_im  out  DATA_WIDTH  registered operands
- mult_res_val  in  1  multiplier result valid
- mult_res_ready  out  1  arbiter takes result
- mult_res_re/_res_im  in  RES_WIDTH  multiplier result
- timeout_err  out  1  sticky, set on any timeout

## Operation
- One operation in flight; FSM states IDLE, ISSUE, WAIT_RES, RETURN.
- IDLE: winner = requester with op_val; if both, the one not last served (last_grant flag). reqW_op_ready = 1 combinationally for winner only; on that edge capture operands and grant id -> ISSUE. Loser sees op_ready = 0.
- ISSUE: mult_op_val = 1, operands from registers, stable until mult_op_ready sampled high -> WAIT_RES.
- WAIT_RES: mult_res_ready = 1; timeout counter increments each cycle. mult_res_val high -> capture re/im, err = 0 -> RETURN. Counter reaches TIMEOUT_CYCLES first -> data 0, err = 1, timeout_err set -> RETURN.
- RETURN: reqG_res_val = 1 for granted requester only, data/err held; on reqG_res_ready -> last_grant = G, IDLE.
- mult_res_val outside WAIT_RES ignored (mult_res_ready = 0).
- Timeout counter cleared on entry to WAIT_RES.

## Timing
- Reset (rstn low, or sw_rst high at edge): state IDLE, all *_val/*_ready outputs 0, result/operand registers 0, err 0, timeout_err 0, last_grant = 1 (requester 0 wins first tie).
- sw_rst mid-operation aborts: no result delivered, in-flight grant dropped; sw_rst wins over every other event in that cycle.
- Accept edge -> mult_op_val high next cycle (1 cycle).
- mult_res_val edge -> reqG_res_val high next cycle.
- Min accept-to-accept period: 4 cycles (multiplier ready immediately, result 1 cycle later, res_ready already high).
- Timeout: res_err asserted TIMEOUT_CYCLES+1 cycles after entering WAIT_RES.
- mult_res_val on the same edge as the timeout terminal count: real result wins, err = 0.
- Requester may drop op_val before accept; no state changes.

## Structure
- Package complex_mult_pkg: FSM state enum (2-bit), default widths, grant id type.
- Sub-module rr_arb2: 2-way round-robin grant from two valids plus last_grant; combinational, reused elsewhere.
- Top holds FSM, operand/result registers, timeout counter ($clog2(TIMEOUT_CYCLES+1) bits).

## Test plan
- Req0 only (2+3i)*(4+2i), multiplier returns 2+16i after 20 cycles -> req0_res_val with re=2, im=16, err=0; req1 outputs stay 0.
- Both op_val high from reset -> req0 served first, then req1; third simultaneous request -> req0 (alternation).
- Multiplier holds op_ready low 5 cycles -> mult_op_val and operands stable for all 5, single accept.
- Multiplier never answers, TIMEOUT_CYCLES=8 -> res_err=1, data 0, timeout_err sticky until sw_rst; next request served normally.
- req0_res_ready held low 10 cycles -> res_val/data held, req1 op_ready stays 0 meanwhile.
- sw_rst pulsed in WAIT_RES -> all outputs at reset values next cycle, mult_sw_rst pulses, late mult_res_val ignored.
